// File: rtl/sprite_pkg.sv
// Shared types and board-tile sprite patterns for the sprite line streamer.
// Patterns are 32 pixels by 16 rows, MSB = leftmost pixel.
package sprite_pkg;

  localparam int PAT_W    = 32;
  localparam int PAT_ROWS = 16;

  typedef logic [PAT_W-1:0] pat_row_t;

  typedef enum logic [2:0] {
    SHIP  = 3'd0,
    EMPTY = 3'd1,
    HIT   = 3'd2,
    MISS  = 3'd3,
    SUNK  = 3'd4
  } tile_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam pat_row_t SHIP_PAT  [PAT_ROWS] = '{default: 32'hFFFF_FFFF};
  localparam pat_row_t EMPTY_PAT [PAT_ROWS] = '{default: 32'h0000_0000};

  // Two 3-pixel strokes converging one pixel per row; row 8 is the crossing.
  localparam pat_row_t HIT_PAT [PAT_ROWS] = '{
    32'h0000_0000, 32'h0000_0000, 32'h01C0_0380, 32'h00E0_0700,
    32'h0070_0E00, 32'h0038_1C00, 32'h001C_3800, 32'h000E_7000,
    32'h0003_C000, 32'h000E_7000, 32'h001C_3800, 32'h0038_1C00,
    32'h0070_0E00, 32'h00E0_0700, 32'h01C0_0380, 32'h0000_0000
  };

  localparam pat_row_t MISS_PAT [PAT_ROWS] = '{
    32'h0000_0000, 32'h0000_0000, 32'h07FF_FFE0, 32'h0700_00E0,
    32'h0700_00E0, 32'h0700_00E0, 32'h0700_00E0, 32'h0700_00E0,
    32'h0700_00E0, 32'h0700_00E0, 32'h0700_00E0, 32'h0700_00E0,
    32'h0700_00E0, 32'h07FF_FFE0, 32'h0000_0000, 32'h0000_0000
  };

  function automatic pat_row_t pattern_row(input int tile, input logic [3:0] row);
    pat_row_t r;
    case (tile)
      int'(SHIP):  r = SHIP_PAT[row];
      int'(EMPTY): r = EMPTY_PAT[row];
      int'(HIT):   r = HIT_PAT[row];
      int'(MISS):  r = MISS_PAT[row];
      int'(SUNK):  r = ~HIT_PAT[row];
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sprite_pattern_lut.sv
// Combinational tile/row to sprite line lookup; out-of-range requests give zero.
// Narrower lines take the leftmost PIX_W pattern pixels, wider lines pad on the right.
module sprite_pattern_lut
  import sprite_pkg::*;
#(
  parameter int PIX_W   = 32,
  parameter int ROWS    = 16,
  parameter int N_TILES = 5
) (
  input  logic [$clog2(N_TILES)-1:0] tile,
  input  logic [$clog2(ROWS)-1:0]    row,
  output logic [PIX_W-1:0]           line
);

  pat_row_t raw;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    raw = '0;
    if (int'(tile) < N_TILES && int'(row) < ROWS && int'(row) < PAT_ROWS)
      raw = pattern_row(int'(tile), 4'(row));
  end

  for (genvar i = 0; i < PIX_W; i++) begin : g_px
    if (i < PAT_W) begin : g_src
      assign line[PIX_W-1-i] = raw[PAT_W-1-i];
    end else begin : g_pad
      assign line[PIX_W-1-i] = 1'b0;
    end
  end

endmodule

// File: rtl/sprite_line_streamer.sv
// Handshaked sprite row source: one parallel line pulse, then a back-pressured
// 1-bit pixel stream with optional mirroring and per-pixel replication.
module sprite_line_streamer
  import sprite_pkg::*;
#(
  parameter int PIX_W   = 32,
  parameter int ROWS    = 16,
  parameter int N_TILES = 5,
  parameter int SCALE_W = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [$clog2(N_TILES)-1:0] req_tile,
  input  logic [$clog2(ROWS)-1:0]    req_row,
  input  logic                       req_mirror,
  input  logic [SCALE_W-1:0]         req_scale,
  output logic                       line_valid,
  output logic [PIX_W-1:0]           line_data,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       pix,
  output logic                       pix_last
);

  localparam int TILE_W = $clog2(N_TILES);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int CNT_W  = $clog2(PIX_W);
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(PIX_W - 1);

  state_t               state;
  logic [TILE_W-1:0]    tile_q;
  logic [ROW_W-1:0]     row_q;
  logic                 mirror_q;
  logic [SCALE_W-1:0]   scale_q;
  logic [PIX_W-1:0]     lut_line;
  logic [PIX_W-1:0]     fetched;
  logic [PIX_W-1:0]     shreg;
  logic [CNT_W-1:0]     pix_cnt;
  logic [SCALE_W-1:0]   rep_cnt;
  logic                 rep_done;

  sprite_pattern_lut #(
    .PIX_W   (PIX_W),
    .ROWS    (ROWS),
    .N_TILES (N_TILES)
  ) u_lut (
    .tile (tile_q),
    .row  (row_q),
    .line (lut_line)
  );

  for (genvar i = 0; i < PIX_W; i++) begin : g_rev
    assign fetched[i] = mirror_q ? lut_line[PIX_W-1-i] : lut_line[i];
  end

  assign rep_done = (rep_cnt == scale_q);
  assign pix      = shreg[PIX_W-1];
  assign pix_last = pix_valid && (pix_cnt == LAST_PIX) && rep_done;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      tile_q     <= '0;
      row_q      <= '0;
      mirror_q   <= 1'b0;
      scale_q    <= '0;
      line_valid <= 1'b0;
      line_data  <= '0;
      pix_valid  <= 1'b0;
      shreg      <= '0;
      pix_cnt    <= '0;
      rep_cnt    <= '0;
    end else begin
      line_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            tile_q    <= req_tile;
            row_q     <= req_row;
            mirror_q  <= req_mirror;
            scale_q   <= req_scale;
            req_ready <= 1'b0;
            state     <= FETCH;
          end else begin
            req_ready <= 1'b1;
          end
        end
        FETCH: begin
          shreg      <= fetched;
          line_data  <= fetched;
          line_valid <= 1'b1;
          pix_valid  <= 1'b1;
          pix_cnt    <= '0;
          rep_cnt    <= '0;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (pix_ready) begin
            if (rep_done) begin
              rep_cnt <= '0;
              pix_cnt <= pix_cnt + CNT_W'(1);
              shreg   <= shreg << 1;
            end else begin
              rep_cnt <= rep_cnt + SCALE_W'(1);
            end
            // Final pixel leaves the shift register empty, so pix idles at 0.
            if (pix_last) begin
              pix_cnt   <= '0;
              pix_valid <= 1'b0;
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_streamer.sv
// Randomised bench for sprite_line_streamer: a default instance and a 16-pixel,
// 15-row instance, both compared every cycle against a pattern-level model.
module tb_sprite_line_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rv_a, rv_b, pr_a, pr_b;
  logic [2:0]  req_tile;
  logic [3:0]  req_row;
  logic        req_mirror;
  logic [1:0]  req_scale;

  logic        rdy_a, lv_a, pv_a, px_a, pl_a;
  logic [31:0] ld_a;
  logic        rdy_b, lv_b, pv_b, px_b, pl_b;
  logic [15:0] ld_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sprite_line_streamer dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_a), .req_ready(rdy_a),
    .req_tile(req_tile), .req_row(req_row), .req_mirror(req_mirror), .req_scale(req_scale),
    .line_valid(lv_a), .line_data(ld_a), .pix_valid(pv_a), .pix_ready(pr_a),
    .pix(px_a), .pix_last(pl_a)
  );

  sprite_line_streamer #(.PIX_W(16), .ROWS(15), .N_TILES(5), .SCALE_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv_b), .req_ready(rdy_b),
    .req_tile(req_tile), .req_row(req_row), .req_mirror(req_mirror), .req_scale(req_scale),
    .line_valid(lv_b), .line_data(ld_b), .pix_valid(pv_b), .pix_ready(pr_b),
    .pix(px_b), .pix_last(pl_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural pattern model ----------------
  function automatic logic [31:0] px_bit(input int p);
    return 32'h8000_0000 >> p;
  endfunction

  function automatic logic [31:0] hit32(input int r);
    logic [31:0] v = '0;
    int rr;
    if (r == 8) begin
      for (int p = 14; p <= 17; p++) v |= px_bit(p);
    end else if (r >= 2 && r <= 14) begin
      rr = (r < 8) ? r : 16 - r;
      for (int p = rr + 5; p <= rr + 7; p++) v |= px_bit(p) | px_bit(31 - p);
    end
    return v;
  endfunction

  function automatic logic [31:0] miss32(input int r);
    logic [31:0] v = '0;
    if (r == 2 || r == 13) begin
      for (int p = 5; p <= 26; p++) v |= px_bit(p);
    end else if (r >= 3 && r <= 12) begin
      for (int p = 5; p <= 7; p++) v |= px_bit(p) | px_bit(31 - p);
    end
    return v;
  endfunction

  function automatic logic [31:0] model_line(input int tile, input int row, input int rows,
                                             input int w, input bit mirror);
    logic [31:0] raw = '0;
    logic [31:0] line, rev;
    if (tile < 5 && row < rows) begin
      case (tile)
        0: raw = 32'hFFFF_FFFF;
        2: raw = hit32(row);
        3: raw = miss32(row);
        4: raw = ~hit32(row);
        default: raw = '0;
      endcase
    end
    line = raw >> (32 - w);
    if (mirror) begin
      rev = '0;
      for (int i = 0; i < w; i++)
        if (((line >> i) & 32'h1) != 0) rev |= 32'h1 << (w - 1 - i);
      line = rev;
    end
    return line;
  endfunction

  // Per-instance model state: 0 = dut_a, 1 = dut_b.
  int          due      [2] = '{0, 0};
  bit          in_line  [2] = '{0, 0};
  int          n_acc    [2] = '{0, 0};
  int          ones_cnt [2] = '{0, 0};
  int          exp_sc   [2] = '{0, 0};
  logic [31:0] exp_ld   [2] = '{0, 0};
  logic [31:0] last_ld  [2] = '{0, 0};
  logic        prev_rst = 1'b0;

  task automatic model_step(input int k, input string pf, input int w, input int rows,
                            input logic rv, input logic prdy, input logic rdy, input logic lv,
                            input logic [31:0] ld, input logic pv, input logic px, input logic pl);
    bit starting, exp_rdy, elast;
    int sc, bp;
    logic epix;
    if (!prev_rst) begin
      check({pf, "rst_line_valid"}, lv, 0);
      check({pf, "rst_pix_valid"}, pv, 0);
      check({pf, "rst_pix_last"}, pl, 0);
      check({pf, "rst_pix"}, px, 0);
      check({pf, "rst_req_ready"}, rdy, 0);
      check({pf, "rst_line_data"}, ld, 0);
      due[k] = 0;
      in_line[k] = 0;
    end else begin
      starting = (due[k] == 1);
      if (starting) begin
        in_line[k]  = 1;
        n_acc[k]    = 0;
        ones_cnt[k] = 0;
        last_ld[k]  = ld;
        check({pf, "line_data"}, ld, exp_ld[k]);
      end
      exp_rdy = !in_line[k] && due[k] == 0;
      check({pf, "line_valid"}, lv, starting);
      check({pf, "pix_valid"}, pv, in_line[k]);
      check({pf, "req_ready"}, rdy, exp_rdy);
      if (in_line[k]) begin
        sc    = exp_sc[k] + 1;
        bp    = n_acc[k] / sc;
        epix  = ((exp_ld[k] >> (w - 1 - bp)) & 32'h1) != 0;
        elast = (n_acc[k] == w * sc - 1);
        check({pf, "pix"}, px, epix);
        check({pf, "pix_last"}, pl, elast);
        if (prdy) begin
          n_acc[k]++;
          if (px) ones_cnt[k]++;
          if (elast) in_line[k] = 0;
        end
      end else begin
        check({pf, "idle_pix_last"}, pl, 0);
      end
      if (due[k] == 2) due[k] = 1;
      else if (starting) due[k] = 0;
      if (rst_n && rv && exp_rdy) begin
        exp_ld[k] = model_line(int'(req_tile), int'(req_row), rows, w, req_mirror);
        exp_sc[k] = int'(req_scale);
        due[k]    = 2;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, "a_", 32, 16, rv_a, pr_a, rdy_a, lv_a, ld_a, pv_a, px_a, pl_a);
    model_step(1, "b_", 16, 15, rv_b, pr_b, rdy_b, lv_b, {16'h0, ld_b}, pv_b, px_b, pl_b);
    prev_rst = rst_n;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic get_ready(input int k);
    return (k == 0) ? rdy_a : rdy_b;
  endfunction

  task automatic set_valid(input int k, input logic v);
    if (k == 0) rv_a = v; else rv_b = v;
  endtask

  task automatic set_pr(input int k, input logic v);
    if (k == 0) pr_a = v; else pr_b = v;
  endtask

  task automatic scramble_fields();
    req_tile   = 3'($urandom);
    req_row    = 4'($urandom);
    req_mirror = 1'($urandom);
    req_scale  = 2'($urandom);
  endtask

  task automatic issue(input int k, input int t, input int r, input int m, input int s);
    int guard = 0;
    while (!get_ready(k) && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("issue_ready", get_ready(k), 1);
    req_tile   = 3'(t);
    req_row    = 4'(r);
    req_mirror = m[0];
    req_scale  = 2'(s);
    set_valid(k, 1'b1);
    @(posedge clk); #1;
    set_valid(k, 1'b0);
    scramble_fields();
    check("accept_drops_ready", get_ready(k), 0);
  endtask

  task automatic run_line(input int k, input bit rnd_ready, input bit noise);
    for (int guard = 0; guard < 2000; guard++) begin
      @(posedge clk); #1;
      if (get_ready(k)) break;
      set_pr(k, rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
      if (noise) begin
        set_valid(k, $urandom_range(0, 1) == 1);
        scramble_fields();
      end
    end
    set_valid(k, 1'b0);
    set_pr(k, 1'b1);
    check("line_done", get_ready(k), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r, m, s;
    rst_n = 1'b0;
    rv_a = 1'b0; rv_b = 1'b0; pr_a = 1'b1; pr_b = 1'b1;
    req_tile = '0; req_row = '0; req_mirror = 1'b0; req_scale = '0;

    // Hand-computed pins on the model itself.
    check("pin_hit_r8",      model_line(2, 8, 16, 32, 0), 32'h0003_C000);
    check("pin_hit_r2",      model_line(2, 2, 16, 32, 0), 32'h01C0_0380);
    check("pin_miss_r2",     model_line(3, 2, 16, 32, 0), 32'h07FF_FFE0);
    check("pin_miss_r3_rev", model_line(3, 3, 16, 32, 1), 32'h0700_00E0);
    check("pin_sunk_r8",     model_line(4, 8, 16, 32, 0), 32'hFFFC_3FFF);
    check("pin_b_hit_r2_rev", model_line(2, 2, 15, 16, 1), 32'h0000_0380);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hit row 8, plain.
    issue(0, 2, 8, 0, 0);
    run_line(0, 0, 0);
    check("hit8_line", last_ld[0], 32'h0003_C000);
    check("hit8_count", n_acc[0], 32);
    check("hit8_ones", ones_cnt[0], 4);

    // Miss row 3, mirrored, doubled pixels.
    issue(0, 3, 3, 1, 1);
    run_line(0, 0, 0);
    check("miss3_line", last_ld[0], 32'h0700_00E0);
    check("miss3_count", n_acc[0], 64);
    check("miss3_ones", ones_cnt[0], 12);

    // Invalid tile gives an all-zero line of full length.
    issue(0, 7, 5, 0, 2);
    run_line(0, 0, 0);
    check("bad_tile_line", last_ld[0], 32'h0);
    check("bad_tile_count", n_acc[0], 96);

    // Ship under random back-pressure with ignored request noise.
    issue(0, 0, 0, 0, 0);
    run_line(0, 1, 1);
    check("ship_line", last_ld[0], 32'hFFFF_FFFF);
    check("ship_ones", ones_cnt[0], 32);

    // Sunk rows.
    issue(0, 4, 0, 0, 0);
    run_line(0, 0, 0);
    check("sunk0_line", last_ld[0], 32'hFFFF_FFFF);
    issue(0, 4, 8, 1, 1);
    run_line(0, 1, 0);
    check("sunk8_line", last_ld[0], 32'hFFFC_3FFF);
    check("sunk8_ones", ones_cnt[0], 56);

    // Reset at pixel 10, then a request presented as reset releases.
    issue(0, 0, 0, 0, 0);
    for (int g = 0; g < 200 && n_acc[0] < 10; g++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_pix_valid", pv_a, 0);
    check("abort_req_ready", rdy_a, 0);
    rst_n = 1'b1;
    req_tile = 3'd2; req_row = 4'd2; req_mirror = 1'b0; req_scale = 2'd3;
    rv_a = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", rdy_a, 1);
    @(posedge clk); #1;
    check("post_rst_accept", rdy_a, 0);
    rv_a = 1'b0;
    scramble_fields();
    run_line(0, 1, 0);
    check("post_rst_line", last_ld[0], 32'h01C0_0380);
    check("post_rst_count", n_acc[0], 128);

    // Random traffic on the default instance.
    repeat (12) begin
      t = $urandom_range(0, 7); r = $urandom_range(0, 15);
      m = $urandom_range(0, 1); s = $urandom_range(0, 3);
      issue(0, t, r, m, s);
      run_line(0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      check("rand_a_count", n_acc[0], 32 * (s + 1));
    end

    // Narrow, 15-row instance.
    issue(1, 0, 15, 0, 0);
    run_line(1, 0, 0);
    check("b_row15_line", last_ld[1], 32'h0);
    check("b_row15_count", n_acc[1], 16);
    issue(1, 2, 2, 1, 2);
    run_line(1, 1, 1);
    check("b_hit2_rev_line", last_ld[1], 32'h0000_0380);
    check("b_hit2_rev_count", n_acc[1], 48);
    repeat (6) begin
      t = $urandom_range(0, 7); r = $urandom_range(0, 15);
      m = $urandom_range(0, 1); s = $urandom_range(0, 3);
      issue(1, t, r, m, s);
      run_line(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      check("rand_b_count", n_acc[1], 16 * (s + 1));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
